// File: rtl/vmask_pkg.sv
// Shared types and width helpers for the vector mask reduction unit.
package vmask_pkg;

  typedef enum logic {
    MODE_CPOP  = 1'b0,
    MODE_FIRST = 1'b1
  } mode_e;

  // Control flags carried through S0 next to the per-beat statistics.
  typedef struct packed {
    logic  valid;
    logic  first;
    logic  last;
    mode_e mode;
  } s0_ctrl_t;

  function automatic int unsigned pc_width(input int unsigned data_width);
    return $clog2(data_width) + 1;
  endfunction

  function automatic int unsigned pos_width(input int unsigned data_width);
    return $clog2(data_width);
  endfunction

  function automatic int unsigned beat_width(input int unsigned max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/vmask_beat_stats.sv
// Combinational per-beat statistics: population count, any-set flag and
// index of the lowest set bit of the active mask.
module vmask_beat_stats
  import vmask_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned PC_W      = pc_width(DATA_WIDTH),
  localparam int unsigned POS_W     = pos_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] act_i,
  output logic [PC_W-1:0]       pc_o_c,
  output logic                  hit_o_c,
  output logic [POS_W-1:0]      pos_o_c
);

  always_comb begin
    pc_o_c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pc_o_c = pc_o_c + PC_W'(act_i[i]);
    end
  end

  assign hit_o_c = |act_i;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    pos_o_c = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (act_i[i]) begin
        pos_o_c = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/vmask_reduce.sv
// Pipelined vcpop.m / vfirst.m mask reduction: S0 per-beat stats, S1
// multi-beat accumulator, S2 registered result strobe.
module vmask_reduce
  import vmask_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned RESP_DATA_WIDTH = 64,
  parameter int unsigned MAX_BEATS       = 8,
  parameter int unsigned VFIRST_ENABLE   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       in_mode,
  input  logic [DATA_WIDTH-1:0]      in_m0,
  input  logic [DATA_WIDTH-1:0]      in_en,
  input  logic [RESP_DATA_WIDTH-1:0] in_count,
  output logic                       out_valid,
  output logic [RESP_DATA_WIDTH-1:0] out_vec
);

  localparam int unsigned PC_W   = pc_width(DATA_WIDTH);
  localparam int unsigned POS_W  = pos_width(DATA_WIDTH);
  localparam int unsigned BEAT_W = beat_width(MAX_BEATS);
  localparam int unsigned IDX_W  = BEAT_W + POS_W;

  logic [DATA_WIDTH-1:0] act_c;
  logic [PC_W-1:0]       pc_c;
  logic                  hit_c;
  logic [POS_W-1:0]      pos_c;

  assign act_c = in_m0 & in_en;

  vmask_beat_stats #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_beat_stats (
    .act_i  (act_c),
    .pc_o_c (pc_c),
    .hit_o_c(hit_c),
    .pos_o_c(pos_c)
  );

  // Operation context and S0 registers
  logic [BEAT_W-1:0]          beat_q, beat_d;
  mode_e                      mode_q, mode_d;
  s0_ctrl_t                   s0_ctrl_q, s0_ctrl_d;
  logic [PC_W-1:0]            s0_pc_q, s0_pc_d;
  logic                       s0_hit_q, s0_hit_d;
  logic [POS_W-1:0]           s0_pos_q, s0_pos_d;
  logic [BEAT_W-1:0]          s0_beat_q, s0_beat_d;
  logic [RESP_DATA_WIDTH-1:0] s0_base_q, s0_base_d;

  // S1 accumulator registers
  logic [RESP_DATA_WIDTH-1:0] acc_q, acc_d;
  logic                       found_q, found_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       done_q, done_d;
  mode_e                      s1_mode_q, s1_mode_d;
  logic                       found_prev_c;

  // S2 output registers
  logic                       out_valid_q, out_valid_d;
  logic [RESP_DATA_WIDTH-1:0] out_vec_q, out_vec_d;

  // Beat index and mode are the running context of the current operation.
  always_comb begin
    beat_d    = beat_q;
    mode_d    = mode_q;
    s0_ctrl_d = '{valid: in_valid, first: in_first, last: in_last, mode: mode_q};
    s0_pc_d   = s0_pc_q;
    s0_hit_d  = s0_hit_q;
    s0_pos_d  = s0_pos_q;
    s0_beat_d = s0_beat_q;
    s0_base_d = s0_base_q;
    if (in_valid) begin
      if (in_first) begin
        beat_d    = '0;
        mode_d    = (VFIRST_ENABLE != 0) ? mode_e'(in_mode) : MODE_CPOP;
        s0_base_d = in_count;
      end else begin
        beat_d    = beat_q + BEAT_W'(1);
      end
      s0_ctrl_d.mode = mode_d;
      s0_pc_d        = pc_c;
      s0_hit_d       = hit_c;
      s0_pos_d       = pos_c;
      s0_beat_d      = beat_d;
    end
  end

  // A first beat restarts both the count and the vfirst search.
  always_comb begin
    acc_d        = acc_q;
    found_d      = found_q;
    idx_d        = idx_q;
    found_prev_c = found_q;
    done_d       = s0_ctrl_q.valid & s0_ctrl_q.last;
    s1_mode_d    = s0_ctrl_q.valid ? s0_ctrl_q.mode : s1_mode_q;
    if (s0_ctrl_q.valid) begin
      acc_d = (s0_ctrl_q.first ? s0_base_q : acc_q) + RESP_DATA_WIDTH'(s0_pc_q);
      if (VFIRST_ENABLE != 0) begin
        found_prev_c = s0_ctrl_q.first ? 1'b0 : found_q;
        found_d      = found_prev_c;
        idx_d        = s0_ctrl_q.first ? '0 : idx_q;
        if (!found_prev_c && s0_hit_q) begin
          found_d = 1'b1;
          idx_d   = {s0_beat_q, s0_pos_q};
        end
      end
    end
  end

  always_comb begin
    out_valid_d = done_q;
    out_vec_d   = out_vec_q;
    if (done_q) begin
      if (s1_mode_q == MODE_FIRST) begin
        out_vec_d = found_q ? RESP_DATA_WIDTH'(idx_q) : '1;
      end else begin
        out_vec_d = acc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q      <= '0;
      mode_q      <= MODE_CPOP;
      s0_ctrl_q   <= '0;
      s0_pc_q     <= '0;
      s0_hit_q    <= 1'b0;
      s0_pos_q    <= '0;
      s0_beat_q   <= '0;
      s0_base_q   <= '0;
      acc_q       <= '0;
      found_q     <= 1'b0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      s1_mode_q   <= MODE_CPOP;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      beat_q      <= beat_d;
      mode_q      <= mode_d;
      s0_ctrl_q   <= s0_ctrl_d;
      s0_pc_q     <= s0_pc_d;
      s0_hit_q    <= s0_hit_d;
      s0_pos_q    <= s0_pos_d;
      s0_beat_q   <= s0_beat_d;
      s0_base_q   <= s0_base_d;
      acc_q       <= acc_d;
      found_q     <= found_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;

endmodule

// File: tb/tb_vmask_reduce.sv
// Self-checking bench for vmask_reduce: directed cases plus randomized
// operations against a beat-level reference model.
module tb_vmask_reduce;

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 64;
  localparam int unsigned MB = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_first;
  logic          in_last;
  logic          in_mode;
  logic [DW-1:0] in_m0;
  logic [DW-1:0] in_en;
  logic [RW-1:0] in_count;
  logic          out_valid;
  logic [RW-1:0] out_vec;

  vmask_reduce #(
    .DATA_WIDTH     (DW),
    .RESP_DATA_WIDTH(RW),
    .MAX_BEATS      (MB),
    .VFIRST_ENABLE  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .in_mode  (in_mode),
    .in_m0    (in_m0),
    .in_en    (in_en),
    .in_count (in_count),
    .out_valid(out_valid),
    .out_vec  (out_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    longint unsigned due;
    logic [RW-1:0]   vec;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: operation-level state, updated per accepted beat.
  logic [RW-1:0] m_acc;
  logic [RW-1:0] m_idx;
  bit            m_found;
  int unsigned   m_beat;
  bit            m_mode;
  logic [RW-1:0] exp_vec;
  logic          exp_v;
  int unsigned   n_strobe = 0;
  logic [RW-1:0] last_strobe = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_acc   = '0;
    m_idx   = '0;
    m_found = 1'b0;
    m_beat  = 0;
    m_mode  = 1'b0;
    exp_vec = '0;
  endtask

  task automatic model_beat(input bit first, input bit last, input bit mode,
                            input logic [DW-1:0] m0, input logic [DW-1:0] en,
                            input logic [RW-1:0] count);
    logic [DW-1:0] act;
    exp_t e;
    act = m0 & en;
    if (first) begin
      m_acc   = count;
      m_found = 1'b0;
      m_idx   = '0;
      m_beat  = 0;
      m_mode  = mode;
    end else begin
      m_beat = (m_beat + 1) % MB;
    end
    m_acc = m_acc + RW'($countones(act));
    if (!m_found) begin
      for (int i = 0; i < DW; i++) begin
        if (act[i]) begin
          m_found = 1'b1;
          m_idx   = RW'(m_beat * DW + i);
          break;
        end
      end
    end
    if (last) begin
      e.due = cyc + 3;
      e.vec = m_mode ? (m_found ? m_idx : {RW{1'b1}}) : m_acc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input bit first, input bit last, input bit mode,
                            input logic [DW-1:0] m0, input logic [DW-1:0] en,
                            input logic [RW-1:0] count);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_first = first;
    in_last  = last;
    in_mode  = mode;
    in_m0    = m0;
    in_en    = en;
    in_count = count;
    model_beat(first, last, mode, m0, en, count);
  endtask

  // Idle cycles carry garbage on the data lines to show they are ignored.
  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      in_mode  = 1'($urandom);
      in_m0    = {$urandom, $urandom};
      in_en    = {$urandom, $urandom};
      in_count = {$urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic expect_result(input string tag, input int unsigned n_before,
                               input int unsigned n_exp, input logic [RW-1:0] v);
    idle(5);
    check_eq({tag, "_strobes"}, 64'(n_strobe - n_before), 64'(n_exp));
    check_eq(tag, last_strobe, v);
  endtask

  // Cycle-accurate monitor: strobe timing, strobe value, and hold between strobes.
  always @(negedge clk) begin
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check_eq("out_valid", 64'(out_valid), 64'(exp_v));
    if (exp_v) begin
      exp_vec = exp_q[0].vec;
      void'(exp_q.pop_front());
    end
    check_eq("out_vec", out_vec, exp_vec);
    if (out_valid === 1'b1) begin
      n_strobe++;
      last_strobe = out_vec;
    end
  end

  function automatic logic [DW-1:0] rand_mask();
    logic [DW-1:0] v;
    case ($urandom % 5)
      0: v = {$urandom, $urandom};
      1: v = DW'(1) << ($urandom % DW);
      2: v = '0;
      3: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      default: v = '1;
    endcase
    return v;
  endfunction

  int unsigned nb;
  int unsigned n0;
  bit          rmode;
  bit          chain;
  logic [RW-1:0] rcount;

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_mode  = 1'b0;
    in_m0    = '0;
    in_en    = '0;
    in_count = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    n0 = n_strobe;
    drive_beat(1, 1, 0, 64'hFFFF_0000_0000_00F1, '1, 64'd10);
    expect_result("cpop_single", n0, 1, 64'd31);

    n0 = n_strobe;
    drive_beat(1, 0, 0, '1, '1, 64'd0);
    drive_beat(0, 0, 0, 64'h5, 64'h1, 64'd0);
    drive_beat(0, 1, 0, 64'h8000_0000_0000_0000, '1, 64'd0);
    expect_result("cpop_3beat", n0, 1, 64'd66);

    n0 = n_strobe;
    drive_beat(1, 0, 1, 64'h10, '0, 64'd0);
    drive_beat(0, 1, 1, 64'h300, '1, 64'd0);
    expect_result("first_2beat", n0, 1, 64'd72);

    n0 = n_strobe;
    drive_beat(1, 0, 1, 64'h10, '0, 64'd0);
    drive_beat(0, 1, 1, 64'h300, '0, 64'd0);
    expect_result("first_none", n0, 1, '1);

    n0 = n_strobe;
    drive_beat(1, 1, 0, 64'hF, '1, 64'd0);
    drive_beat(1, 1, 1, 64'h80, '1, 64'd0);
    expect_result("back_to_back", n0, 2, 64'd7);

    n0 = n_strobe;
    drive_beat(1, 0, 0, 64'h3, '1, 64'd0);
    idle(2);
    drive_beat(0, 1, 0, 64'h3, '1, 64'd0);
    expect_result("bubbles", n0, 1, 64'd4);

    drive_beat(1, 0, 0, '1, '1, 64'd0);
    do_reset();
    check_eq("rst_out_vec", out_vec, 64'd0);
    n0 = n_strobe;
    drive_beat(1, 1, 0, 64'h1, '1, 64'd0);
    expect_result("after_reset", n0, 1, 64'd1);

    for (int op = 0; op < 400; op++) begin
      nb     = 1 + ($urandom % MB);
      rmode  = 1'($urandom);
      chain  = ($urandom % 12) == 0;
      rcount = ($urandom % 2 == 0) ? RW'($urandom % 100) : {$urandom, $urandom};
      for (int b = 0; b < nb; b++) begin
        drive_beat((b == 0) && !chain, b == nb - 1, rmode, rand_mask(), rand_mask(), rcount);
        if ($urandom % 4 == 0) idle($urandom % 3);
      end
      if ($urandom % 3 == 0) idle(1 + $urandom % 2);
    end

    idle(6);
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
